// File: rtl/mopshub_power_init_sm.sv
// Sequential CAN-bus power-up sequencer for the MOPS-Hub, with optional per-bus oscillator trim.
// Define MOPSHUB_INIT_STATUS_EN to add the trim_ok_mask status output.
module mopshub_power_init_sm #(
  parameter int BUS_W        = 5,
  parameter int SETTLE_CYC   = 400,
  parameter int TRIM_TIMEOUT = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] n_buses,
  input  logic             start_init,
  input  logic             osc_auto_trim,
  input  logic             trim_done,
  output logic             power_bus_en,
  output logic [BUS_W-1:0] power_bus_cnt,
  output logic             start_trim_ack,
  output logic             end_trim_bus,
  output logic             end_power_init,
  output logic             busy,
  output logic             timeout_err,
  output logic [BUS_W-1:0] err_bus
`ifdef MOPSHUB_INIT_STATUS_EN
  ,
  output logic [2**BUS_W-1:0] trim_ok_mask
`endif
);

  localparam int CNT_MAX = (SETTLE_CYC > TRIM_TIMEOUT) ? SETTLE_CYC : TRIM_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_SETTLE,
    S_TRIM_REQ,
    S_TRIM_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUS_W-1:0]   bus_q, bus_d;
  logic               trim_q, trim_d;
  logic               timeout_q, timeout_d;
  logic [BUS_W-1:0]   err_bus_q, err_bus_d;
`ifdef MOPSHUB_INIT_STATUS_EN
  logic               ok_q, ok_d;
  logic [2**BUS_W-1:0] mask_q, mask_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bus_q     <= '0;
      trim_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_bus_q <= '0;
`ifdef MOPSHUB_INIT_STATUS_EN
      ok_q      <= 1'b0;
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_q     <= bus_d;
      trim_q    <= trim_d;
      timeout_q <= timeout_d;
      err_bus_q <= err_bus_d;
`ifdef MOPSHUB_INIT_STATUS_EN
      ok_q      <= ok_d;
      mask_q    <= mask_d;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus_d          = bus_q;
    trim_d         = trim_q;
    timeout_d      = timeout_q;
    err_bus_d      = err_bus_q;
`ifdef MOPSHUB_INIT_STATUS_EN
    ok_d           = ok_q;
    mask_d         = mask_q;
`endif
    power_bus_en   = 1'b0;
    start_trim_ack = 1'b0;
    end_trim_bus   = 1'b0;
    end_power_init = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_init) begin
          trim_d    = osc_auto_trim;
          timeout_d = 1'b0;
          err_bus_d = '0;
          bus_d     = '0;
`ifdef MOPSHUB_INIT_STATUS_EN
          mask_d    = '0;
`endif
          state_d   = S_ENABLE;
        end
      end
      S_ENABLE: begin
        power_bus_en = 1'b1;
        cnt_d        = CNT_W'(SETTLE_CYC - 1);
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        power_bus_en = 1'b1;
        if (cnt_q == '0) state_d = trim_q ? S_TRIM_REQ : S_NEXT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_TRIM_REQ: begin
        power_bus_en   = 1'b1;
        start_trim_ack = 1'b1;
        cnt_d          = CNT_W'(TRIM_TIMEOUT - 1);
`ifdef MOPSHUB_INIT_STATUS_EN
        ok_d           = 1'b0;
`endif
        state_d        = S_TRIM_WAIT;
      end
      S_TRIM_WAIT: begin
        power_bus_en = 1'b1;
        // A completion arriving on the expiry cycle still counts as success.
        if (trim_done) begin
`ifdef MOPSHUB_INIT_STATUS_EN
          ok_d    = 1'b1;
`endif
          state_d = S_NEXT;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          err_bus_d = bus_q;
          state_d   = S_NEXT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_NEXT: begin
        power_bus_en = 1'b1;
        end_trim_bus = trim_q;
`ifdef MOPSHUB_INIT_STATUS_EN
        if (trim_q && ok_q) mask_d[bus_q] = 1'b1;
`endif
        // Compare before incrementing so the last index never wraps.
        if (bus_q == n_buses) begin
          state_d = S_DONE;
        end else begin
          bus_d   = bus_q + 1'b1;
          state_d = S_ENABLE;
        end
      end
      S_DONE: begin
        end_power_init = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign power_bus_cnt = bus_q;
  assign timeout_err   = timeout_q;
  assign err_bus       = err_bus_q;
`ifdef MOPSHUB_INIT_STATUS_EN
  assign trim_ok_mask  = mask_q;
`endif

endmodule

// File: tb/tb_mopshub_power_init_sm.sv
// Self-checking bench for mopshub_power_init_sm: directed scenarios plus randomized runs
// compared against per-bus latency/outcome arithmetic.
module tb_mopshub_power_init_sm;

  localparam int BUS_W  = 5;
  localparam int SETTLE = 400;
  localparam int TMO    = 2000;

  logic             clk = 1'b0;
  logic             rst;
  logic [BUS_W-1:0] n_buses;
  logic             start_init;
  logic             osc_auto_trim;
  logic             trim_done;
  logic             power_bus_en;
  logic [BUS_W-1:0] power_bus_cnt;
  logic             start_trim_ack;
  logic             end_trim_bus;
  logic             end_power_init;
  logic             busy;
  logic             timeout_err;
  logic [BUS_W-1:0] err_bus;
`ifdef MOPSHUB_INIT_STATUS_EN
  logic [2**BUS_W-1:0] trim_ok_mask;
`endif

  int n_vec = 0;
  int n_err = 0;
  int dly[32];  // per-bus trim response delay after start_trim_ack; 0 = never answer

  mopshub_power_init_sm #(
    .BUS_W(BUS_W), .SETTLE_CYC(SETTLE), .TRIM_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .n_buses(n_buses), .start_init(start_init),
    .osc_auto_trim(osc_auto_trim), .trim_done(trim_done),
    .power_bus_en(power_bus_en), .power_bus_cnt(power_bus_cnt),
    .start_trim_ack(start_trim_ack), .end_trim_bus(end_trim_bus),
    .end_power_init(end_power_init), .busy(busy),
    .timeout_err(timeout_err), .err_bus(err_bus)
`ifdef MOPSHUB_INIT_STATUS_EN
    , .trim_ok_mask(trim_ok_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full power-up sequence. Called #1 after a clock edge with the DUT idle.
  task automatic run_seq(input string tag, input int n, input bit trim, input bit noise);
    int c, exp_c, acks, ends, sched, win_end, w;
    bit done_seen, order_ok, en_ok;
    logic exp_err;
    logic [31:0] exp_eb, exp_mask;

    exp_c = 1; exp_err = 1'b0; exp_eb = 0; exp_mask = 0;
    for (int b = 0; b <= n; b++) begin
      exp_c += SETTLE + 2;
      if (trim) begin
        w = (dly[b] == 0 || dly[b] > TMO) ? TMO : dly[b];
        exp_c += 1 + w;
        if (dly[b] == 0 || dly[b] > TMO) begin
          exp_err = 1'b1;
          exp_eb  = b;
        end else begin
          exp_mask[b] = 1'b1;
        end
      end
    end

    n_buses       = BUS_W'(n);
    osc_auto_trim = trim;
    start_init    = 1'b1;
    c = 0; acks = 0; ends = 0; sched = -1; win_end = -1;
    done_seen = 1'b0; order_ok = 1'b1; en_ok = 1'b1;

    while (!done_seen && c < exp_c + 100) begin
      step();
      c++;
      start_init = 1'b0;
      trim_done  = 1'b0;
      if (c == 1) begin
        check({tag, "_en_first"}, power_bus_en, 1);
        check({tag, "_cnt_first"}, power_bus_cnt, 0);
        check({tag, "_err_cleared"}, timeout_err, 0);
      end
      if (busy !== 1'b1) en_ok = 1'b0;
      if (power_bus_en !== !end_power_init) en_ok = 1'b0;
      if (start_trim_ack) begin
        if (power_bus_cnt !== BUS_W'(acks)) order_ok = 1'b0;
        acks++;
        w       = dly[power_bus_cnt];
        sched   = (w == 0) ? -1 : c + w;
        win_end = c + ((w == 0 || w > TMO) ? TMO : w);
      end
      if (end_trim_bus) ends++;
      if (c == sched) trim_done = 1'b1;
      else if (noise && c > win_end && $urandom_range(0, 5) == 0) trim_done = 1'b1;
      if (noise && $urandom_range(0, 9) == 0) start_init = 1'b1;
      if (noise) osc_auto_trim = 1'($urandom);
      if (end_power_init) done_seen = 1'b1;
    end
    start_init = 1'b0;
    trim_done  = 1'b0;

    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_latency"}, c, exp_c);
    check({tag, "_trim_acks"}, acks, trim ? n + 1 : 0);
    check({tag, "_end_trims"}, ends, trim ? n + 1 : 0);
    check({tag, "_ack_order"}, order_ok, 1);
    check({tag, "_en_busy"}, en_ok, 1);
    check({tag, "_last_cnt"}, power_bus_cnt, n);
    check({tag, "_timeout_err"}, timeout_err, exp_err);
    if (exp_err) check({tag, "_err_bus"}, err_bus, exp_eb);
`ifdef MOPSHUB_INIT_STATUS_EN
    check({tag, "_mask"}, trim_ok_mask, exp_mask);
`endif
    step();
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int pulses;
    int n;
    bit tr;

    rst = 1'b0; n_buses = '0; start_init = 1'b0; osc_auto_trim = 1'b0; trim_done = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_outs", {power_bus_en, start_trim_ack, end_trim_bus, end_power_init, timeout_err}, 0);
    check("rst_cnt", power_bus_cnt, 0);
    check("rst_err_bus", err_bus, 0);
    rst = 1'b1;
    step();

    // Reset in the middle of bus 3's settle window aborts with no end pulse.
    n_buses = 5'd15; osc_auto_trim = 1'b0; start_init = 1'b1;
    step();
    start_init = 1'b0;
    for (int i = 0; i < 4000 && power_bus_cnt != 5'd3; i++) step();
    repeat (100) step();
    check("rsth_in_bus3", power_bus_cnt, 3);
    rst = 1'b0;
    pulses = 0;
    step();
    check("rsth_busy", busy, 0);
    check("rsth_outs", {power_bus_en, start_trim_ack, end_trim_bus, end_power_init, timeout_err}, 0);
    check("rsth_cnt", power_bus_cnt, 0);
    repeat (4) begin step(); pulses += int'(end_power_init); end
    rst = 1'b1;
    repeat (20) begin step(); pulses += int'(end_power_init) + int'(busy); end
    check("rsth_no_end", pulses, 0);

    for (int b = 0; b < 32; b++) dly[b] = 50;
    run_seq("notrim16", 15, 1'b0, 1'b1);
    run_seq("trim4", 3, 1'b1, 1'b0);

    dly[0] = 50; dly[1] = 0; dly[2] = 50;
    run_seq("timeout", 2, 1'b1, 1'b0);

    dly[0] = TMO; dly[1] = TMO;
    run_seq("race", 1, 1'b1, 1'b1);

    dly[0] = 50;
    run_seq("single", 0, 1'b0, 1'b1);
    run_seq("restart", 0, 1'b1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      n  = $urandom_range(0, 4);
      tr = 1'($urandom);
      for (int b = 0; b < 32; b++) begin
        case ($urandom_range(0, 9))
          0:       dly[b] = 0;
          1:       dly[b] = TMO;
          default: dly[b] = $urandom_range(1, 120);
        endcase
      end
      run_seq($sformatf("rand%0d", r), n, tr, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mopshub_power_init_sm.md
Name: mopshub_power_init_sm

Overview:
- Sequencer that powers up the CAN buses of the MOPS-Hub one at a time after start-up.
- Optionally requests an oscillator auto-trim on each bus.
- Sits directly upstream of the hub core's bus-init logic. It drives power_bus_en / power_bus_cnt / start_trim_ack / end_trim_bus / end_power_init, which the core and the bench data generator consume.
- Waits for trim completion from the per-bus trim handler, with a timeout.

Parameters:
- BUS_W, 5, width of bus index; max supported buses = 2**BUS_W.
- SETTLE_CYC, 400, clock cycles waited after enabling a bus before trim or advance (10 us at 40 MHz).
- TRIM_TIMEOUT, 2000, clock cycles allowed in TRIM_WAIT before declaring a trim failure.

Ports:
- clk  in  1  system clock (40 MHz).
- rst  in  1  synchronous, active-low reset.
- n_buses  in  BUS_W  index of the last bus to initialise (15 → buses 0..15).
- start_init  in  1  start request; sampled only in IDLE.
- osc_auto_trim  in  1  trim enable; latched at start_init.
- trim_done  in  1  one-cycle pulse from trim handler: current bus trimmed.
- power_bus_en  out  1  high while the bus at power_bus_cnt is being enabled/trimmed.
- power_bus_cnt  out  BUS_W  index of the bus currently handled.
- start_trim_ack  out  1  one-cycle trim request for power_bus_cnt.
- end_trim_bus  out  1  one-cycle pulse when a trimmed bus is finished (success or timeout).
- end_power_init  out  1  one-cycle pulse when all buses are done.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set on any trim timeout; cleared on accepted start_init.
- err_bus  out  BUS_W  index of the most recent bus that timed out.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; all outputs 0; counters 0. Reset mid-sequence aborts immediately, with no end pulses.
- IDLE:
  - On start_init=1, latch osc_auto_trim into trim_q.
  - Clear timeout_err and err_bus; set power_bus_cnt=0.
  - Go to ENABLE.
- ENABLE (1 cycle): power_bus_en=1; load settle counter with SETTLE_CYC-1; go to SETTLE. power_bus_en is 1 exactly one cycle after start_init is sampled.
- SETTLE:
  - Decrement the counter each cycle.
  - At 0: go to TRIM_REQ if trim_q=1, else NEXT.
  - SETTLE lasts exactly SETTLE_CYC cycles.
- TRIM_REQ (1 cycle): start_trim_ack=1; load timeout counter with TRIM_TIMEOUT-1; go to TRIM_WAIT.
- TRIM_WAIT:
  - trim_done=1 → NEXT (success).
  - Otherwise decrement; at 0 → set timeout_err=1 and err_bus=power_bus_cnt, then NEXT.
  - trim_done in the same cycle as expiry counts as success.
- NEXT (1 cycle):
  - end_trim_bus=1 if trim_q=1; power_bus_en=1.
  - If power_bus_cnt==n_buses → DONE.
  - Else power_bus_cnt+1 → ENABLE.
- DONE (1 cycle): end_power_init=1; power_bus_en=0; power_bus_cnt held; go to IDLE.
- power_bus_en is 1 in ENABLE, SETTLE, TRIM_REQ, TRIM_WAIT and NEXT; 0 in IDLE and DONE.
- Ignored inputs:
  - start_init outside IDLE is ignored (no queuing).
  - trim_done outside TRIM_WAIT is ignored.
  - osc_auto_trim changes after latch have no effect.
- Boundaries:
  - n_buses=0 → a single bus is handled.
  - n_buses=2**BUS_W-1 → all buses handled; no wrap, the comparison ends the sequence before increment.
  - n_buses is sampled continuously and must be held stable while busy=1.
- Total latency without trim: (n_buses+1)·(SETTLE_CYC+2)+1 cycles from start_init to end_power_init.

Optional Feature:
- Macro: MOPSHUB_INIT_STATUS_EN.
- When defined:
  - Adds output trim_ok_mask, width 2**BUS_W.
  - Bit i is set in NEXT when bus i finished TRIM_WAIT via trim_done.
  - The mask clears on accepted start_init, resets to 0, and holds after DONE.
  - Busses not trimmed (trim_q=0) leave their bits 0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset hold: rst=0 for 5 cycles mid-SETTLE of bus 3 → next cycle all outputs 0, busy=0, no end_power_init pulse.
- No-trim sweep: n_buses=15, osc_auto_trim=0, SETTLE_CYC=400, start_init pulse → power_bus_cnt steps 0..15; zero start_trim_ack/end_trim_bus; end_power_init exactly 6433 cycles after start_init.
- Trim sweep: n_buses=3, osc_auto_trim=1, bench returns trim_done 50 cycles after each start_trim_ack → 4 start_trim_ack, 4 end_trim_bus, timeout_err=0; trim_ok_mask=0x000F if macro enabled.
- Timeout: n_buses=2, trim, bench never answers bus 1 → timeout_err=1, err_bus=1 after TRIM_TIMEOUT cycles; bus 2 still processed; end_power_init pulses; mask=0x0005 if enabled.
- Race: trim_done asserted exactly on the final TRIM_WAIT cycle → success (timeout_err stays 0); stray trim_done in SETTLE → ignored.
- Single bus and re-start: n_buses=0 → one bus, end_power_init; start_init during busy → ignored; second start_init after DONE → clears timeout_err and restarts at bus 0.
